// File: rtl/exc_pkg.sv
// Shared types and helpers for the exception sequencer.
package exc_pkg;

    typedef enum logic [1:0] {EXS_IDLE, EXS_RAISE, EXS_HANDLER} exc_state_t;

    localparam logic [3:0] EST_NONE = 4'd0;

    // Cause code reported to the exception unit: source index plus one, so zero means "none".
    function automatic logic [3:0] est_code(input int idx);
        return 4'(idx + 1);
    endfunction

endpackage

// File: rtl/exc_sequencer_prio_enc.sv
// Combinational priority encoder: lowest set index wins.
module prio_enc #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan downward so the lowest set bit is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/exc_sequencer.sv
// Sticky exception collector with fixed priority selection, ack timeout/retry
// and a handler window that blocks new raises until ERet.
module exc_sequencer
    import exc_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] exc_req,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_d,
    input  logic             ExcAck,
    input  logic             ERet,
    output logic             Exc,
    output logic [3:0]       EStatus,
    output logic             Busy,
    output logic [N_SRC-1:0] pend_q,
    output logic [N_SRC-1:0] mask_q,
    output logic             AckErr
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT);

    exc_state_t       state;
    logic [TW-1:0]    timer;
    logic [N_SRC-1:0] eligible;
    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic [N_SRC-1:0] pend_clr;
    logic [N_SRC-1:0] pend_ret;
    logic [N_SRC-1:0] pend_nxt;
    logic             timeout;

    assign eligible = pend_q & ~mask_q;
    assign timeout  = (timer == TW'(ACK_TIMEOUT - 1));
    assign Busy     = (state != EXS_IDLE);

    prio_enc #(.N(N_SRC)) u_prio (
        .req   (eligible),
        .valid (win_vld),
        .idx   (win_idx)
    );

    // A fresh request always beats the selection clear on the same edge.
    always_comb begin
        pend_clr = '0;
        pend_ret = '0;
        if (state == EXS_IDLE && win_vld)
            pend_clr[win_idx] = 1'b1;
        if (state == EXS_RAISE && !ExcAck && timeout) begin
            for (int i = 0; i < N_SRC; i++)
                pend_ret[i] = (EStatus == est_code(i));
        end
        pend_nxt = (pend_q & ~pend_clr) | pend_ret | exc_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= EXS_IDLE;
            Exc     <= 1'b0;
            EStatus <= EST_NONE;
            pend_q  <= '0;
            mask_q  <= '0;
            timer   <= '0;
            AckErr  <= 1'b0;
        end else begin
            pend_q <= pend_nxt;
            if (mask_we) mask_q <= mask_d;
            case (state)
                EXS_IDLE: begin
                    if (win_vld) begin
                        state   <= EXS_RAISE;
                        Exc     <= 1'b1;
                        EStatus <= est_code(32'(win_idx));
                        timer   <= '0;
                    end
                end
                EXS_RAISE: begin
                    // Ack takes precedence over an expiring timer.
                    if (ExcAck) begin
                        state <= EXS_HANDLER;
                        Exc   <= 1'b0;
                    end else if (timeout) begin
                        state   <= EXS_IDLE;
                        Exc     <= 1'b0;
                        EStatus <= EST_NONE;
                        AckErr  <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                EXS_HANDLER: begin
                    if (ERet) begin
                        state   <= EXS_IDLE;
                        EStatus <= EST_NONE;
                    end
                end
                default: begin
                    state   <= EXS_IDLE;
                    Exc     <= 1'b0;
                    EStatus <= EST_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: priority, masking, timeout retry, set-beats-clear, async reset.
module tb_exc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] exc_req;
    logic       mask_we;
    logic [3:0] mask_d;
    logic       ExcAck;
    logic       ERet;
    logic       Exc;
    logic [3:0] EStatus;
    logic       Busy;
    logic [3:0] pend_q;
    logic [3:0] mask_q;
    logic       AckErr;

    int errors = 0;
    int checks = 0;

    exc_sequencer #(.N_SRC(4), .ACK_TIMEOUT(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .exc_req (exc_req),
        .mask_we (mask_we),
        .mask_d  (mask_d),
        .ExcAck  (ExcAck),
        .ERet    (ERet),
        .Exc     (Exc),
        .EStatus (EStatus),
        .Busy    (Busy),
        .pend_q  (pend_q),
        .mask_q  (mask_q),
        .AckErr  (AckErr)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then stable and inputs may be changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_and_return();
        ExcAck = 1'b1; tick(); ExcAck = 1'b0;
        ERet = 1'b1; tick(); ERet = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; exc_req = '0; mask_we = 1'b0; mask_d = '0; ExcAck = 1'b0; ERet = 1'b0;
        tick(); tick();
        checks++;
        if (Exc !== 1'b0 || EStatus !== 4'd0 || Busy !== 1'b0 || pend_q !== 4'b0 ||
            mask_q !== 4'b0 || AckErr !== 1'b0) begin
            errors++;
            $display("FAIL reset: Exc=%b EStatus=%0d Busy=%b pend=%b mask=%b AckErr=%b, want all 0",
                     Exc, EStatus, Busy, pend_q, mask_q, AckErr);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        exc_req = 4'b0100; tick(); exc_req = '0;
        checks++;
        if (pend_q !== 4'b0100 || Exc !== 1'b0) begin
            errors++;
            $display("FAIL single_pend: pend=%b Exc=%b, want 0100/0", pend_q, Exc);
        end
        tick();
        checks++;
        if (Exc !== 1'b1 || EStatus !== 4'd3 || pend_q !== 4'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL single_raise: Exc=%b EStatus=%0d pend=%b Busy=%b, want 1/3/0000/1",
                     Exc, EStatus, pend_q, Busy);
        end
        ExcAck = 1'b1; tick(); ExcAck = 1'b0;
        tick();
        checks++;
        if (Exc !== 1'b0 || Busy !== 1'b1 || EStatus !== 4'd3) begin
            errors++;
            $display("FAIL single_handler: Exc=%b Busy=%b EStatus=%0d, want 0/1/3", Exc, Busy, EStatus);
        end
        ERet = 1'b1; tick(); ERet = 1'b0;
        checks++;
        if (EStatus !== 4'd0 || Busy !== 1'b0 || Exc !== 1'b0) begin
            errors++;
            $display("FAIL single_eret: EStatus=%0d Busy=%b Exc=%b, want 0/0/0", EStatus, Busy, Exc);
        end
    endtask

    task automatic test_priority();
        exc_req = 4'b1010; tick(); exc_req = '0;
        tick();
        checks++;
        if (Exc !== 1'b1 || EStatus !== 4'd2 || pend_q !== 4'b1000) begin
            errors++;
            $display("FAIL prio_first: Exc=%b EStatus=%0d pend=%b, want 1/2/1000", Exc, EStatus, pend_q);
        end
        ExcAck = 1'b1; tick(); ExcAck = 1'b0;
        ERet = 1'b1; tick(); ERet = 1'b0;
        checks++;
        if (Exc !== 1'b0 || Busy !== 1'b0 || pend_q !== 4'b1000) begin
            errors++;
            $display("FAIL prio_gap: Exc=%b Busy=%b pend=%b, want 0/0/1000", Exc, Busy, pend_q);
        end
        tick();
        checks++;
        if (Exc !== 1'b1 || EStatus !== 4'd4 || pend_q !== 4'b0) begin
            errors++;
            $display("FAIL prio_second: Exc=%b EStatus=%0d pend=%b, want 1/4/0000", Exc, EStatus, pend_q);
        end
        ack_and_return();
    endtask

    task automatic test_mask();
        mask_we = 1'b1; mask_d = 4'b0001; tick(); mask_we = 1'b0;
        exc_req = 4'b0001; tick(); exc_req = '0;
        // Stray ExcAck/ERet in IDLE must be ignored.
        ExcAck = 1'b1; ERet = 1'b1; tick(); ExcAck = 1'b0; ERet = 1'b0;
        tick();
        checks++;
        if (mask_q !== 4'b0001 || pend_q !== 4'b0001 || Exc !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL mask_hold: mask=%b pend=%b Exc=%b Busy=%b, want 0001/0001/0/0",
                     mask_q, pend_q, Exc, Busy);
        end
        mask_we = 1'b1; mask_d = 4'b0000; tick(); mask_we = 1'b0;
        checks++;
        if (Exc !== 1'b0 || mask_q !== 4'b0000) begin
            errors++;
            $display("FAIL mask_clear: Exc=%b mask=%b, want 0/0000", Exc, mask_q);
        end
        tick();
        checks++;
        if (Exc !== 1'b1 || EStatus !== 4'd1 || pend_q !== 4'b0) begin
            errors++;
            $display("FAIL mask_raise: Exc=%b EStatus=%0d pend=%b, want 1/1/0000", Exc, EStatus, pend_q);
        end
        ack_and_return();
    endtask

    task automatic test_timeout();
        exc_req = 4'b0010; tick(); exc_req = '0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (Exc !== 1'b1 || AckErr !== 1'b0) begin
            errors++;
            $display("FAIL timeout_last: Exc=%b AckErr=%b, want 1/0", Exc, AckErr);
        end
        tick();
        checks++;
        if (Exc !== 1'b0 || AckErr !== 1'b1 || pend_q !== 4'b0010 || EStatus !== 4'd0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: Exc=%b AckErr=%b pend=%b EStatus=%0d Busy=%b, want 0/1/0010/0/0",
                     Exc, AckErr, pend_q, EStatus, Busy);
        end
        tick();
        checks++;
        if (Exc !== 1'b1 || EStatus !== 4'd2 || pend_q !== 4'b0) begin
            errors++;
            $display("FAIL timeout_retry: Exc=%b EStatus=%0d pend=%b, want 1/2/0000", Exc, EStatus, pend_q);
        end
        // Ack in the very cycle the timer expires must win.
        for (int i = 0; i < 15; i++) tick();
        ExcAck = 1'b1; tick(); ExcAck = 1'b0;
        checks++;
        if (Busy !== 1'b1 || Exc !== 1'b0 || EStatus !== 4'd2 || pend_q !== 4'b0 || AckErr !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ackwins: Busy=%b Exc=%b EStatus=%0d pend=%b AckErr=%b, want 1/0/2/0000/1",
                     Busy, Exc, EStatus, pend_q, AckErr);
        end
        ERet = 1'b1; tick(); ERet = 1'b0;
    endtask

    task automatic test_set_beats_clear();
        exc_req = 4'b0001; tick();
        // exc_req[0] stays high across the selection edge.
        tick(); exc_req = '0;
        checks++;
        if (Exc !== 1'b1 || EStatus !== 4'd1 || pend_q !== 4'b0001) begin
            errors++;
            $display("FAIL sbc_keep: Exc=%b EStatus=%0d pend=%b, want 1/1/0001", Exc, EStatus, pend_q);
        end
        ack_and_return();
        checks++;
        if (Busy !== 1'b0 || pend_q !== 4'b0001) begin
            errors++;
            $display("FAIL sbc_idle: Busy=%b pend=%b, want 0/0001", Busy, pend_q);
        end
        tick();
        checks++;
        if (Exc !== 1'b1 || EStatus !== 4'd1 || pend_q !== 4'b0) begin
            errors++;
            $display("FAIL sbc_reservice: Exc=%b EStatus=%0d pend=%b, want 1/1/0000", Exc, EStatus, pend_q);
        end
        ack_and_return();
    endtask

    task automatic test_reset_in_handler();
        exc_req = 4'b0110; tick(); exc_req = '0;
        tick();
        ExcAck = 1'b1; tick(); ExcAck = 1'b0;
        exc_req = 4'b0010; tick(); exc_req = '0;
        checks++;
        if (Busy !== 1'b1 || pend_q !== 4'b0110 || EStatus !== 4'd2) begin
            errors++;
            $display("FAIL rst_setup: Busy=%b pend=%b EStatus=%0d, want 1/0110/2", Busy, pend_q, EStatus);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (Exc !== 1'b0 || EStatus !== 4'd0 || pend_q !== 4'b0 || Busy !== 1'b0 || AckErr !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: Exc=%b EStatus=%0d pend=%b Busy=%b AckErr=%b, want all 0",
                     Exc, EStatus, pend_q, Busy, AckErr);
        end
        #1 reset = 1'b0;
        tick(); tick();
        checks++;
        if (Exc !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: Exc=%b Busy=%b, want 0/0", Exc, Busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_timeout();
        test_set_beats_clear();
        test_reset_in_handler();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
